// File: rtl/seven_segment_display_arbiter.sv
// Round-robin arbiter that time-shares one seven-segment display driver between
// several clients, with a minimum hold time per grant and a hold-lock input.
module seven_segment_display_arbiter #(
  parameter int n_client    = 4,
  parameter int w_digit     = 2,
  parameter int hold_cycles = 25_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [n_client-1:0]           req,
  input  logic [n_client*w_digit*4-1:0] number_in,
  input  logic [n_client*w_digit-1:0]   dots_in,
  input  logic                          lock,
  output logic [n_client-1:0]           grant,
  output logic [$clog2(n_client)-1:0]   active,
  output logic                          busy,
  output logic                          switched,
  output logic [w_digit*4-1:0]          number,
  output logic [w_digit-1:0]            dots,
  output logic                          fsm_state
);

  localparam int aw = $clog2(n_client);
  localparam int cw = $clog2(hold_cycles + 1);
  localparam int nw = w_digit * 4;
  localparam logic [cw-1:0] cnt_max = cw'(hold_cycles - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state, state_next;
  logic [n_client-1:0] grant_next;
  logic [aw-1:0]       active_next;
  logic                busy_next;
  logic                switched_next;
  logic [nw-1:0]       number_next;
  logic [w_digit-1:0]  dots_next;
  logic [cw-1:0]       cnt, cnt_next;

  logic [aw-1:0]       pick;
  logic                other_req;
  logic                take_pick;
  int                  idx;

  // fsm_state: 0 = IDLE, 1 = HOLD
  assign fsm_state = (state == HOLD);

  // Search downward so the nearest requester after active wins; active itself is last.
  always_comb begin
    pick = active;
    idx  = 0;
    for (int i = n_client; i >= 1; i--) begin
      idx = (int'(active) + i) % n_client;
      if (req[idx]) pick = aw'(idx);
    end
    other_req = |(req & ~grant);
  end

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    active_next   = active;
    busy_next     = busy;
    switched_next = 1'b0;
    cnt_next      = cnt;
    number_next   = number;
    dots_next     = dots;
    take_pick     = 1'b0;

    if (state == IDLE) begin
      take_pick = |req;
    end else if (!req[active]) begin
      if (other_req) begin
        take_pick = 1'b1;
      end else begin
        state_next  = IDLE;
        grant_next  = '0;
        busy_next   = 1'b0;
        number_next = '0;
        dots_next   = '0;
      end
    end else if (cnt == cnt_max && !lock && other_req) begin
      take_pick = 1'b1;
    end else begin
      if (cnt != cnt_max) cnt_next = cnt + cw'(1);
      number_next = number_in[int'(active)*nw +: nw];
      dots_next   = dots_in[int'(active)*w_digit +: w_digit];
    end

    // take_pick only fires when pick differs from the current grant (or from idle).
    if (take_pick) begin
      state_next    = HOLD;
      grant_next    = '0;
      grant_next[pick] = 1'b1;
      active_next   = pick;
      busy_next     = 1'b1;
      switched_next = 1'b1;
      cnt_next      = '0;
      number_next   = number_in[int'(pick)*nw +: nw];
      dots_next     = dots_in[int'(pick)*w_digit +: w_digit];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      active   <= aw'(n_client - 1);
      busy     <= 1'b0;
      switched <= 1'b0;
      cnt      <= '0;
      number   <= '0;
      dots     <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      active   <= active_next;
      busy     <= busy_next;
      switched <= switched_next;
      cnt      <= cnt_next;
      number   <= number_next;
      dots     <= dots_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// Directed bench for seven_segment_display_arbiter with n_client=4, w_digit=2,
// hold_cycles=8: a per-step vector table plus hand-written multi-cycle sequences.
module tb_seven_segment_display_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] number_in = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0]  dots_in   = {2'b01, 2'b11, 2'b10, 2'b01};
  logic        lock = 1'b0;
  logic [3:0]  grant;
  logic [1:0]  active;
  logic        busy;
  logic        switched;
  logic [7:0]  number;
  logic [1:0]  dots;
  logic        fsm_state;

  int errors = 0;
  int checks = 0;

  seven_segment_display_arbiter #(
    .n_client(4), .w_digit(2), .hold_cycles(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .number_in(number_in), .dots_in(dots_in),
    .lock(lock), .grant(grant), .active(active), .busy(busy), .switched(switched),
    .number(number), .dots(dots), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       lock;
    int         reps;
    logic [3:0] g;
    logic [1:0] a;
    logic       b;
    logic       s;
    logic [7:0] n;
    logic [1:0] d;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " grant"},    32'(grant),    32'(v.g));
    check({tag, " active"},   32'(active),   32'(v.a));
    check({tag, " busy"},     32'(busy),     32'(v.b));
    check({tag, " switched"}, 32'(switched), 32'(v.s));
    check({tag, " number"},   32'(number),   32'(v.n));
    check({tag, " dots"},     32'(dots),     32'(v.d));
    check({tag, " state"},    32'(fsm_state), 32'(v.b));
  endtask

  logic [3:0] rr_seq [3];
  logic [7:0] rr_num [3];
  logic [3:0] cur_g;
  vec_t       v;

  initial begin
    //            rst   req      lock reps grant    act   busy  sw    number dots
    vecs[0]  = '{1'b1, 4'b1111, 1'b0, 1,  4'b0000, 2'd3, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[1]  = '{1'b0, 4'b1111, 1'b0, 1,  4'b0001, 2'd0, 1'b1, 1'b1, 8'h11, 2'b01};
    vecs[2]  = '{1'b0, 4'b0100, 1'b0, 1,  4'b0100, 2'd2, 1'b1, 1'b1, 8'h33, 2'b11};
    vecs[3]  = '{1'b0, 4'b0100, 1'b0, 3,  4'b0100, 2'd2, 1'b1, 1'b0, 8'h33, 2'b11};
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1,  4'b0000, 2'd2, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 2,  4'b0000, 2'd2, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[6]  = '{1'b0, 4'b0100, 1'b0, 1,  4'b0100, 2'd2, 1'b1, 1'b1, 8'h33, 2'b11};
    vecs[7]  = '{1'b0, 4'b0010, 1'b0, 1,  4'b0010, 2'd1, 1'b1, 1'b1, 8'h22, 2'b10};
    vecs[8]  = '{1'b0, 4'b0001, 1'b0, 1,  4'b0001, 2'd0, 1'b1, 1'b1, 8'h11, 2'b01};
    vecs[9]  = '{1'b0, 4'b0011, 1'b1, 20, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h11, 2'b01};
    vecs[10] = '{1'b0, 4'b0011, 1'b0, 1,  4'b0010, 2'd1, 1'b1, 1'b1, 8'h22, 2'b10};
    vecs[11] = '{1'b0, 4'b0010, 1'b0, 5,  4'b0010, 2'd1, 1'b1, 1'b0, 8'h22, 2'b10};
    vecs[12] = '{1'b1, 4'b0010, 1'b0, 1,  4'b0000, 2'd3, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[13] = '{1'b0, 4'b0011, 1'b0, 1,  4'b0001, 2'd0, 1'b1, 1'b1, 8'h11, 2'b01};

    step();
    for (int i = 0; i < 14; i++) begin
      rst  = vecs[i].rst;
      req  = vecs[i].req;
      lock = vecs[i].lock;
      for (int r = 0; r < vecs[i].reps; r++) begin
        step();
        check($sformatf("vec%0d.%0d grant", i, r), 32'(grant), 32'(vecs[i].g));
      end
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Round-robin with req=1011: each grant lasts exactly 8 cycles, client 2 skipped.
    rst = 1'b1; req = 4'b1011; lock = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rr first grant", 32'(grant), 32'(4'b0001));
    check("rr first switched", 32'(switched), 32'd1);
    rr_seq[0] = 4'b0010; rr_seq[1] = 4'b1000; rr_seq[2] = 4'b0001;
    rr_num[0] = 8'h22;   rr_num[1] = 8'h44;   rr_num[2] = 8'h11;
    cur_g = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 7; c++) begin
        step();
        check($sformatf("rr%0d dwell%0d grant", k, c), 32'(grant), 32'(cur_g));
        check($sformatf("rr%0d dwell%0d switched", k, c), 32'(switched), 32'd0);
      end
      step();
      check($sformatf("rr%0d grant", k), 32'(grant), 32'(rr_seq[k]));
      check($sformatf("rr%0d switched", k), 32'(switched), 32'd1);
      check($sformatf("rr%0d number", k), 32'(number), 32'(rr_num[k]));
      cur_g = rr_seq[k];
    end

    // Lone requester: one switch pulse, number follows client 3 with one cycle of lag.
    req = 4'b1000;
    step();
    check("lone grant", 32'(grant), 32'(4'b1000));
    check("lone switched", 32'(switched), 32'd1);
    check("lone active", 32'(active), 32'd3);
    for (int c = 0; c < 29; c++) begin
      if (c == 10) begin
        number_in[31:24] = 8'hA5;
        #1;
        check("lone number before edge", 32'(number), 32'h44);
      end
      step();
      check($sformatf("lone%0d grant", c), 32'(grant), 32'(4'b1000));
      check($sformatf("lone%0d switched", c), 32'(switched), 32'd0);
      if (c == 10) check("lone number after edge", 32'(number), 32'hA5);
    end
    number_in[31:24] = 8'h44;

    v = '{1'b0, 4'b0000, 1'b0, 0, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h00, 2'b00};
    req = 4'b0000;
    step();
    v.a = 2'd3;
    check_all("lone release", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_display_arbiter.md
# seven_segment_display_arbiter

Time-shares one `seven_segment_display` instance between `n_client` requesters, such as a counter lab, a FIFO-lab status view and a debug view. Selection is round-robin. Each grant has a minimum hold time so a value stays readable before the display switches to the next requester. The block sits directly upstream of the display driver: its `number`/`dots` outputs connect to the driver's `number`/`dots` inputs. It also returns a one-hot grant to the clients.

## Interface
- `n_client`, default 4: number of requesters; must be ≥ 2.
- `w_digit`, default 2: digits per value; must match the downstream display driver.
- `hold_cycles`, default 25_000_000: minimum grant duration in clk cycles (0.5 s at 50 MHz); must be ≥ 1.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `req`, input, `n_client`: per-client display request, level-sensitive.
- `number_in`, input, `n_client*w_digit*4`: client k's value in bits `[k*w_digit*4 +: w_digit*4]`.
- `dots_in`, input, `n_client*w_digit`: client k's dots in bits `[k*w_digit +: w_digit]`.
- `lock`, input, 1: while high, expiry-driven switching is suppressed.
- `grant`, output, `n_client`: one-hot grant, registered; all zero when idle.
- `active`, output, `$clog2(n_client)`: index of the granted client; holds the last granted index when idle.
- `busy`, output, 1: high while a grant is held.
- `switched`, output, 1: one-cycle pulse on every cycle where `grant` changes to a different nonzero value.
- `number`, output, `w_digit*4`: registered value to the display driver.
- `dots`, output, `w_digit`: registered dots to the display driver.

## Operation
- **Reset values:** state IDLE, `grant` = 0, `busy` = 0, `switched` = 0, `number` = 0, `dots` = 0, `active` = n_client-1, hold counter `cnt` = 0.
- **Counter:** `cnt` is `$clog2(hold_cycles+1)` bits wide and saturates at hold_cycles-1. The hold is expired when `cnt == hold_cycles-1`.
- **Round-robin pick:** the first k with `req[k]=1`, searching from `active+1` upward and wrapping modulo n_client. The current client is considered last. After reset, client 0 has top priority.
- **IDLE state:**
  - If any `req` is high, pick a client k and go to HOLD.
  - On that transition: `grant` = one-hot(k), `active` = k, `busy` = 1, `cnt` = 0, `switched` = 1.
- **HOLD state, current client c:**
  - If `req[c]=0` and another client requests: switch immediately, ignoring both `cnt` and `lock`. `cnt` = 0, `switched` = 1.
  - If `req[c]=0` and no client requests: go to IDLE with `grant` = 0, `busy` = 0, `number` = 0, `dots` = 0. `switched` stays 0.
  - If `req[c]=1`, the hold is expired, `lock=0`, and some other client requests: switch to the round-robin pick. `cnt` = 0, `switched` = 1.
  - Otherwise: stay. `cnt` increments up to saturation. With saturation, a later request from another client causes a switch on the first cycle it is sampled, provided `lock=0`.
- **Data path:** every cycle in HOLD, `number`/`dots` register the slice of `number_in`/`dots_in` belonging to the grant value being written on that edge. Values therefore track the granted client's live inputs with one cycle of latency.
- **Simultaneous events:**
  - `rst` overrides everything.
  - A release and a new request on the same cycle produce a direct switch, with no IDLE cycle in between.
  - Several requesters are resolved by round-robin order only.
- **Reset mid-grant:** all outputs return to their reset values on the next edge. No partial hold time is carried over.
- The block never drives `switched` for a re-grant to the same client.

## Timing
- `req` sampled at edge t drives `grant`/`busy`/`number` valid after edge t, i.e. 1-cycle latency.
- Minimum dwell: a client that keeps requesting holds the display for at least `hold_cycles` cycles while others request. The switch occurs on the edge where `cnt` is already hold_cycles-1 and another request is present.
- Release latency is 1 cycle from `req[c]` falling to `grant` change.
- `lock` is sampled per cycle. Deasserting it with an expired counter and a pending request switches on the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use n_client=4, w_digit=2, hold_cycles=8.

1. **Reset:** pulse `rst` with `req`=4'b1111 → after reset, outputs `grant`=0, `number`=0, `active`=3. First edge with `rst`=0 → `grant`=4'b0001, `switched`=1, `number`=`number_in[7:0]` of client 0.
2. **Round-robin:** hold `req`=4'b1011 → grant sequence 0001→0010→1000→0001. Each grant lasts exactly 8 cycles, and `switched` pulses once per change.
3. **Release:**
   - With only client 2 granted, drop `req[2]` → next edge `grant`=0, `busy`=0, `number`=0, `dots`=0.
   - Drop `req[2]` while `req[1]` rises on the same cycle → next edge `grant`=4'b0010 with no idle cycle.
4. **Lock:** client 0 granted, `req`=4'b0011, `lock`=1 for 20 cycles → `grant` stays 0001. Drop `lock` → next edge `grant`=0010.
5. **Lone requester:** only `req[3]` high for 30 cycles → `grant`=1000 throughout, `switched` pulses exactly once. `number` follows `number_in[31:24]` with 1-cycle lag (e.g. drive 8'hA5 → `number`=8'hA5 one cycle later).
6. **Reset mid-grant:** assert `rst` at `cnt`=5 of client 1's grant → next edge all outputs at reset values. After release, client 0 has priority over client 1.
